// File: rtl/sti_rcv.sv
// Serial-to-parallel word receiver: reassembles 8/16/24/32-bit serial words into a 16-bit payload,
// flags non-zero pad bits and truncated words; results appear one cycle after the last bit.
module sti_rcv (
   input  logic        clk,
   input  logic        reset,
   input  logic        si_valid,
   input  logic        si_data,
   input  logic        cfg_load,
   input  logic [1:0]  cfg_length,
   input  logic        cfg_msb,
   input  logic        cfg_low,
   input  logic        cfg_fill,
   output logic [15:0] po_data,
   output logic        po_valid,
   output logic        po_err,
   output logic        po_busy,
   output logic [7:0]  po_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_RECV  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;

   logic [1:0]  r_len;
   logic        r_msb;
   logic        r_low;
   logic        r_fill;
   logic [31:0] r_frame;
   logic [4:0]  r_idx;

   logic [4:0]  w_last_idx;
   logic [4:0]  w_first_idx;
   logic [4:0]  w_idx;
   logic        w_take;
   logic        w_last;
   logic [31:0] w_frame_nx;
   logic [15:0] w_payload;
   logic        w_pad_err;

   // Index of the highest bit of the word: 8*(len+1)-1.
   assign w_last_idx  = {r_len, 3'b111};
   assign w_first_idx = r_msb ? w_last_idx : 5'd0;
   assign w_idx       = (r_state == S_ARMED) ? w_first_idx : r_idx;
   // A cfg_load cycle swallows any bit presented alongside it.
   assign w_take      = si_valid && !cfg_load && (r_state != S_IDLE);
   assign w_last      = (r_state == S_RECV) &&
                        (r_msb ? (r_idx == 5'd0) : (r_idx == w_last_idx));
   assign po_busy     = (r_state == S_RECV);

   always_comb begin
      w_frame_nx        = (r_state == S_ARMED) ? 32'd0 : r_frame;
      w_frame_nx[w_idx] = si_data;
   end

   always_comb begin
      w_payload = 16'd0;
      w_pad_err = 1'b0;
      case (r_len)
         2'd0: w_payload = r_low ? {w_frame_nx[7:0], 8'h00} : {8'h00, w_frame_nx[7:0]};
         2'd1: w_payload = w_frame_nx[15:0];
         2'd2: begin
            w_payload = r_fill ? w_frame_nx[23:8] : w_frame_nx[15:0];
            w_pad_err = r_fill ? (|w_frame_nx[7:0]) : (|w_frame_nx[23:16]);
         end
         default: begin
            w_payload = r_fill ? w_frame_nx[31:16] : w_frame_nx[15:0];
            w_pad_err = r_fill ? (|w_frame_nx[15:0]) : (|w_frame_nx[31:16]);
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (cfg_load) w_state_nx = S_ARMED;
         end
         S_ARMED: begin
            if (!cfg_load && si_valid) w_state_nx = S_RECV;
         end
         S_RECV: begin
            if (cfg_load || !si_valid || w_last) w_state_nx = S_ARMED;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_len    <= 2'd0;
         r_msb    <= 1'b0;
         r_low    <= 1'b0;
         r_fill   <= 1'b0;
         r_frame  <= 32'd0;
         r_idx    <= 5'd0;
         po_data  <= 16'd0;
         po_valid <= 1'b0;
         po_err   <= 1'b0;
         po_count <= 8'd0;
      end else begin
         po_valid <= 1'b0;
         po_err   <= 1'b0;
         if (cfg_load) begin
            r_len  <= cfg_length;
            r_msb  <= cfg_msb;
            r_low  <= cfg_low;
            r_fill <= cfg_fill;
         end
         if (w_take) begin
            r_frame <= w_frame_nx;
            // Index may run off the end after the final bit; the next word reloads it.
            r_idx   <= r_msb ? (w_idx - 5'd1) : (w_idx + 5'd1);
            if (w_last) begin
               po_valid <= 1'b1;
               po_data  <= w_payload;
               po_err   <= w_pad_err;
               po_count <= po_count + 8'd1;
            end
         end else if ((r_state == S_RECV) && !si_valid && !cfg_load) begin
            po_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sti_rcv.sv
// Randomized scoreboard bench for sti_rcv: stimulus tasks queue expected results from a
// payload/pad level model, a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_sti_rcv;

   logic        clk = 1'b0;
   logic        reset;
   logic        si_valid;
   logic        si_data;
   logic        cfg_load;
   logic [1:0]  cfg_length;
   logic        cfg_msb;
   logic        cfg_low;
   logic        cfg_fill;
   logic [15:0] po_data;
   logic        po_valid;
   logic        po_err;
   logic        po_busy;
   logic [7:0]  po_count;

   sti_rcv dut (
      .clk        (clk),
      .reset      (reset),
      .si_valid   (si_valid),
      .si_data    (si_data),
      .cfg_load   (cfg_load),
      .cfg_length (cfg_length),
      .cfg_msb    (cfg_msb),
      .cfg_low    (cfg_low),
      .cfg_fill   (cfg_fill),
      .po_data    (po_data),
      .po_valid   (po_valid),
      .po_err     (po_err),
      .po_busy    (po_busy),
      .po_count   (po_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        vld;
      logic [15:0] data;
      logic        err;
      logic [7:0]  cnt;
      int          cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   int          m_len  = 0;
   logic        m_msb  = 1'b0;
   logic        m_low  = 1'b0;
   logic        m_fill = 1'b0;
   logic        m_cfgd = 1'b0;
   logic [7:0]  m_cnt  = 8'd0;
   logic [15:0] m_data = 16'd0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b0 && (po_valid === 1'b1 || po_err === 1'b1)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output valid=%b err=%b data=%h cyc=%0d", po_valid, po_err, po_data, cyc);
         end else begin
            mon_e = q.pop_front();
            chk("out_valid", 32'(po_valid), 32'(mon_e.vld));
            chk("out_err",   32'(po_err),   32'(mon_e.err));
            chk("out_data",  32'(po_data),  32'(mon_e.data));
            chk("out_count", 32'(po_count), 32'(mon_e.cnt));
            chk("out_cycle", cyc,           mon_e.cyc);
         end
      end
   end

   task automatic step(input logic v, input logic d, input logic ld);
      si_valid = v;
      si_data  = d;
      cfg_load = ld;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      repeat (k) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_cfg(input int len, input logic msb, input logic low, input logic fill, input logic with_bit);
      cfg_length = len[1:0];
      cfg_msb    = msb;
      cfg_low    = low;
      cfg_fill   = fill;
      step(with_bit, 1'($urandom), 1'b1);
      m_len  = len;
      m_msb  = msb;
      m_low  = low;
      m_fill = fill;
      m_cfgd = 1'b1;
      chk("busy_after_cfg", 32'(po_busy), 32'd0);
   endtask

   // Lay payload and pad out in the frame as the configured format describes.
   function automatic void build(input logic [15:0] pay, input logic [15:0] pad,
                                 output logic [31:0] fr, output logic [15:0] d, output logic e);
      case (m_len)
         0: begin
            fr = 32'(pay % 16'd256);
            d  = m_low ? 16'((pay % 16'd256) * 16'd256) : (pay % 16'd256);
            e  = 1'b0;
         end
         1: begin
            fr = 32'(pay);
            d  = pay;
            e  = 1'b0;
         end
         2: begin
            fr = m_fill ? (32'(pay) * 32'd256 + 32'(pad % 16'd256))
                        : (32'(pad % 16'd256) * 32'd65536 + 32'(pay));
            d  = pay;
            e  = (pad % 16'd256) != 16'd0;
         end
         default: begin
            fr = m_fill ? (32'(pay) * 32'd65536 + 32'(pad)) : (32'(pad) * 32'd65536 + 32'(pay));
            d  = pay;
            e  = pad != 16'd0;
         end
      endcase
   endfunction

   task automatic send(input logic [31:0] fr, input logic [15:0] d, input logic e,
                       input int nb, input logic trunc);
      int   n;
      int   idx;
      logic last;
      n = 8 * (m_len + 1);
      for (int k = 0; k < nb; k++) begin
         idx  = m_msb ? (n - 1 - k) : k;
         last = (k == n - 1);
         if (m_cfgd && last) begin
            m_cnt  = m_cnt + 8'd1;
            m_data = d;
            q.push_back(exp_t'{1'b1, d, e, m_cnt, cyc + 1});
         end
         step(1'b1, fr[idx], 1'b0);
         chk("busy", 32'(po_busy), 32'(m_cfgd && !last));
      end
      if (trunc) begin
         if (m_cfgd && nb > 0 && nb < n)
            q.push_back(exp_t'{1'b0, m_data, 1'b1, m_cnt, cyc + 1});
         step(1'b0, 1'b0, 1'b0);
         chk("busy_trunc", 32'(po_busy), 32'd0);
      end
   endtask

   task automatic word(input logic [15:0] pay, input logic [15:0] pad, input int nb, input logic trunc);
      logic [31:0] fr;
      logic [15:0] d;
      logic        e;
      build(pay, pad, fr, d, e);
      send(fr, d, e, nb, trunc);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog cycle budget expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          kind;
      logic [15:0] pad;
      reset = 1'b1;
      si_valid = 1'b0; si_data = 1'b0; cfg_load = 1'b0;
      cfg_length = 2'd0; cfg_msb = 1'b0; cfg_low = 1'b0; cfg_fill = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_data",  32'(po_data),  32'd0);
      chk("rst_valid", 32'(po_valid), 32'd0);
      chk("rst_err",   32'(po_err),   32'd0);
      chk("rst_busy",  32'(po_busy),  32'd0);
      chk("rst_count", 32'(po_count), 32'd0);
      reset = 1'b0;
      idle(2);

      // Unconfigured: bits are ignored.
      word(16'h00A7, 16'h0, 8, 1'b1);

      do_cfg(1, 1'b1, 1'b0, 1'b0, 1'b0);
      word(16'hA5C3, 16'h0, 16, 1'b0);
      idle(2);
      chk("count_first", 32'(po_count), 32'd1);

      do_cfg(0, 1'b0, 1'b1, 1'b0, 1'b0);
      word(16'h003C, 16'h0, 8, 1'b0);
      idle(1);

      do_cfg(3, 1'b1, 1'b0, 1'b1, 1'b0);
      word(16'h1234, 16'h0000, 32, 1'b0);
      word(16'h1234, 16'h0008, 32, 1'b0);
      idle(2);

      do_cfg(2, 1'b0, 1'b0, 1'b0, 1'b0);
      word(16'h00FF, 16'h0, 24, 1'b0);
      word(16'hBEEF, 16'h0, 24, 1'b0);
      idle(2);

      word(16'h5555, 16'h0, 5, 1'b1);
      idle(1);

      word(16'h7777, 16'h0, 6, 1'b0);
      do_cfg(1, 1'b0, 1'b0, 1'b0, 1'b1);
      word(16'hC0DE, 16'h0, 16, 1'b0);
      idle(1);

      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(9, 0) < 2)
            do_cfg(int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         n    = 8 * (m_len + 1);
         pad  = ($urandom_range(2, 0) == 0) ? 16'($urandom) : 16'd0;
         kind = int'($urandom_range(5, 0));
         if (kind == 0) begin
            word(16'($urandom), pad, int'($urandom_range(n - 1, 1)), 1'b1);
         end else if (kind == 1) begin
            word(16'($urandom), pad, int'($urandom_range(n - 1, 1)), 1'b0);
            do_cfg(int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         end else begin
            word(16'($urandom), pad, n, 1'b0);
            idle(int'($urandom_range(2, 0)));
         end
      end
      idle(2);

      // Reset in the middle of a word.
      do_cfg(1, 1'b1, 1'b0, 1'b0, 1'b0);
      word(16'hFFFF, 16'h0, 7, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_data",  32'(po_data),  32'd0);
      chk("midrst_valid", 32'(po_valid), 32'd0);
      chk("midrst_err",   32'(po_err),   32'd0);
      chk("midrst_busy",  32'(po_busy),  32'd0);
      chk("midrst_count", 32'(po_count), 32'd0);
      m_cnt = 8'd0; m_data = 16'd0; m_cfgd = 1'b0;
      m_len = 0; m_msb = 1'b0; m_low = 1'b0; m_fill = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      word(16'h00FF, 16'h0, 8, 1'b1);
      idle(1);
      do_cfg(0, 1'b1, 1'b0, 1'b0, 1'b0);
      word(16'h0081, 16'h0, 8, 1'b0);
      idle(3);

      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
